// File: rtl/encoder_arbiter.sv
// rtl/encoder_arbiter.sv - registered request-word encoder with fixed/round-robin arbitration
module encoder_arbiter #(
  parameter int                 N_IN         = 32,
  parameter int                 OUT_W        = $clog2(N_IN),
  parameter int                 MODE         = 0,
  parameter logic [OUT_W-1:0]   DEFAULT_CODE = {OUT_W{1'b1}},
  parameter int                 CNT_W        = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [N_IN-1:0]   req_in,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [OUT_W-1:0]  code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              none_hit,
  output logic              multi_hit,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic             state;
  logic [OUT_W-1:0] rr_ptr;
  logic             accept;
  logic             word_none;
  logic             word_multi;
  logic [OUT_W-1:0] low_code;
  logic [OUT_W-1:0] rr_code;
  logic [OUT_W-1:0] rr_next;
  logic [OUT_W-1:0] enc_code;

  assign code_valid = (state == FULL);
  assign req_ready  = !code_valid || code_ready;
  assign accept     = req_valid && req_ready;

  // Classify the incoming word: clearing the lowest set bit leaves something iff >=2 bits are set.
  always_comb begin
    word_none  = (req_in == '0);
    word_multi = |(req_in & (req_in - 1'b1));
  end

  // Lowest set index; scanning downward lets the lowest match overwrite higher ones.
  always_comb begin
    low_code = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (req_in[i]) low_code = OUT_W'(i);
    end
  end

  // Round-robin search: first set bit at or after rr_ptr, wrapping past N_IN-1 back to 0.
  always_comb begin
    logic [OUT_W:0]   sum;
    logic [OUT_W-1:0] idx;
    logic             found;
    rr_code = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int j = 0; j < N_IN; j++) begin
      sum = {1'b0, rr_ptr} + (OUT_W+1)'(j);
      if (sum >= (OUT_W+1)'(N_IN)) sum = sum - (OUT_W+1)'(N_IN);
      idx = sum[OUT_W-1:0];
      if (!found && req_in[idx]) begin
        rr_code = idx;
        found   = 1'b1;
      end
    end
  end

  // Pointer moves to just past the granted index, wrapping at N_IN.
  always_comb begin
    logic [OUT_W:0] nx;
    nx      = {1'b0, rr_code} + 1'b1;
    rr_next = (nx == (OUT_W+1)'(N_IN)) ? '0 : nx[OUT_W-1:0];
  end

  // Select the code to capture: default for empty words, arbitration result for multi-bit words.
  always_comb begin
    if (word_none)                     enc_code = DEFAULT_CODE;
    else if (word_multi && MODE == 1)  enc_code = rr_code;
    else                               enc_code = low_code;
  end

  // Output stage: capture on accept, drain on downstream consume, hold otherwise.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= EMPTY;
      code_out  <= DEFAULT_CODE;
      none_hit  <= 1'b0;
      multi_hit <= 1'b0;
    end else if (accept) begin
      state     <= FULL;
      code_out  <= enc_code;
      none_hit  <= word_none;
      multi_hit <= word_multi;
    end else if (code_valid && code_ready) begin
      state     <= EMPTY;
    end
  end

  // Round-robin pointer only advances when arbitration actually resolved a conflict.
  always_ff @(posedge clock) begin
    if (!clear) begin
      rr_ptr <= '0;
    end else if (MODE == 1 && accept && word_multi) begin
      rr_ptr <= rr_next;
    end
  end

  // Saturating count of accepted malformed (zero or multi-bit) words.
  always_ff @(posedge clock) begin
    if (!clear) begin
      err_count <= '0;
    end else if (accept && (word_none || word_multi) && err_count != {CNT_W{1'b1}}) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
